// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution address/loop-count stage.
// Holds width defaults, header-decode constants and the decoded strobe bundle.
package conv_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DIM_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;

    // sel value that, together with a backward input-PC step, marks the row turn-around
    localparam logic [1:0] SEL_ROW_END = 2'b00;

    // smallest header dimension that still yields at least one output column/row
    localparam int DIM_MIN = 3;

    typedef struct packed {
        logic hdr_x;
        logic hdr_y;
        logic row_end;
        logic col_step;
    } strobe_t;

endpackage

// File: rtl/conv_updown_cnt.sv
// Wrapping up/down counter with synchronous clear; opposing requests hold the
// count and raise a one-cycle conflict pulse.
module conv_updown_cnt #(
    parameter int W = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] count,
    output logic         conflict
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (up && !dn) begin
            count <= count + ONE;
        end else if (dn && !up) begin
            count <= count - ONE;
        end
    end

    // a clear in the same cycle overrides the request, so it is not a conflict
    assign conflict = up & dn & ~clear;

endmodule

// File: rtl/conv_addr_gen.sv
// Address and loop-count stage beside the conv controller FSM: input/output SRAM
// addresses, header dimension capture, column/row tracking and loop flags.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              PCout,
    input  logic              flush,
    input  logic              data_or_dim,
    input  logic              x_or_y,
    input  logic              weight_data_sel,
    input  logic [1:0]        sel,
    input  logic              we,
    input  logic              Out_PC_inc,
    input  logic              Out_PC_out,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_we,
    output logic              x_dim_zero_flag,
    output logic              x_dim_sec_flag,
    output logic              stopper,
    output logic              err_incdec
);

    localparam logic [DIM_W-1:0] D_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

    // header dimension -> loop count (valid 3x3 window positions), zero below DIM_MIN
    function automatic logic [DIM_W-1:0] dim_to_count(input logic [DIM_W-1:0] d);
        return (d >= DIM_W'(DIM_MIN)) ? d - DIM_W'(2) : '0;
    endfunction

    logic [DIM_W-1:0] x_dim;
    logic [DIM_W-1:0] col_left;
    logic [DIM_W-1:0] col_total;
    logic [DIM_W-1:0] rows_left;
    logic             done;
    logic [DIM_W-1:0] hdr_count;
    logic             in_conflict;
    logic             row_end_live;
    strobe_t          stb;

    assign stb.hdr_x    = PCout & ~data_or_dim & ~x_or_y & weight_data_sel;
    assign stb.hdr_y    = PCout & ~data_or_dim & x_or_y;
    assign stb.row_end  = PCout & dec & ~inc & data_or_dim & (sel == SEL_ROW_END);
    assign stb.col_step = Out_PC_inc & (col_left != '0);

    assign hdr_count    = dim_to_count(sram_rdata[DIM_W-1:0]);
    // a turn-around after the last row is ignored entirely
    assign row_end_live = stb.row_end & (rows_left != '0);

    conv_updown_cnt #(.W(ADDR_W)) u_in_pc (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .up       (PCout & inc),
        .dn       (PCout & dec),
        .count    (in_addr),
        .conflict (in_conflict)
    );

    logic unused_out_conflict;

    conv_updown_cnt #(.W(ADDR_W)) u_out_pc (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .up       (Out_PC_inc),
        .dn       (1'b0),
        .count    (out_addr),
        .conflict (unused_out_conflict)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_dim     <= '0;
            col_left  <= '0;
            col_total <= '0;
            rows_left <= '0;
            done      <= 1'b0;
        end else if (flush) begin
            x_dim     <= '0;
            col_left  <= '0;
            col_total <= '0;
            rows_left <= '0;
            done      <= 1'b0;
        end else begin
            // header capture beats reload, reload beats a column step
            if (stb.hdr_x) begin
                x_dim     <= sram_rdata[DIM_W-1:0];
                col_total <= hdr_count;
                col_left  <= hdr_count;
            end else if (row_end_live) begin
                col_left <= col_total;
            end else if (stb.col_step) begin
                col_left <= col_left - D_ONE;
            end

            if (stb.hdr_y) begin
                rows_left <= hdr_count;
                if (hdr_count == '0 || col_total == '0)
                    done <= 1'b1;
            end else if (row_end_live) begin
                rows_left <= rows_left - D_ONE;
                if (rows_left == D_ONE)
                    done <= 1'b1;
            end
        end
    end

    // survives flush so the FSM fault is visible until a full reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_incdec <= 1'b0;
        else if (in_conflict)
            err_incdec <= 1'b1;
    end

    assign x_dim_zero_flag = (col_left <= D_ONE) & (col_total != '0);
    assign x_dim_sec_flag  = (col_left <= (col_total >> 1)) & (col_total != '0);
    assign stopper         = done;
    assign out_we          = we & Out_PC_out;

    logic unused_bits;
    assign unused_bits = ^{sram_rdata[DATA_W-1:DIM_W], x_dim};

endmodule
